m_mem_access: RTL and testbench

// M-stage load/store unit between the pipeline and a variable-latency data memory.

---
 rtl/m_mem_if.sv | 42 ++++
 rtl/m_mem_access.sv | 172 +++++++++++++++++
 tb/tb_m_mem_access.sv | 281 ++++++++++++++++++++++++++++
 3 files changed

// File: rtl/m_mem_if.sv
// Bus bundle for the M-stage load/store unit: pipeline-side request/response
// plus the data-memory request channel.
//
// Handshakes: the pipeline holds req_valid/mem_op/addr/wdata stable while busy
// is high; done pulses for exactly one cycle when the instruction retires.
// On the memory side m_req is held high, with m_addr/m_we/m_byteen/m_wdata
// stable, until a cycle in which m_ack is high; m_rdata is sampled in that
// same cycle.
`timescale 1ns/1ps
interface m_mem_if;
  logic        req_valid;
  logic [2:0]  mem_op;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic        busy;
  logic        done;
  logic [31:0] rdata;
  logic        adel;
  logic        ades;
  logic        err;
  logic        m_req;
  logic [31:0] m_addr;
  logic        m_we;
  logic [3:0]  m_byteen;
  logic [31:0] m_wdata;
  logic        m_ack;
  logic [31:0] m_rdata;

  // Environment view: drives the pipeline request and the memory response.
  modport master (
    output req_valid, mem_op, addr, wdata, m_ack, m_rdata,
    input  busy, done, rdata, adel, ades, err,
    input  m_req, m_addr, m_we, m_byteen, m_wdata
  );

  // Load/store unit view.
  modport slave (
    input  req_valid, mem_op, addr, wdata, m_ack, m_rdata,
    output busy, done, rdata, adel, ades, err,
    output m_req, m_addr, m_we, m_byteen, m_wdata
  );
endinterface

// File: rtl/m_mem_access.sv
// M-stage load/store unit. Formats stores onto byte lanes, extracts and
// extends loads, checks alignment and bounds the memory wait with a timeout.
`timescale 1ns/1ps
module m_mem_access #(
  parameter int MAX_WAIT = 15
) (
  input  logic       clk,
  input  logic       reset,
  m_mem_if.slave     bus,
  output logic [1:0] state_dbg
);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  localparam logic [2:0] OP_LW  = 3'b000;
  localparam logic [2:0] OP_LH  = 3'b001;
  localparam logic [2:0] OP_LHU = 3'b010;
  localparam logic [2:0] OP_LB  = 3'b011;
  localparam logic [2:0] OP_LBU = 3'b100;
  localparam logic [2:0] OP_SW  = 3'b101;
  localparam logic [2:0] OP_SH  = 3'b110;
  localparam logic [2:0] OP_SB  = 3'b111;

  localparam int CW = $clog2(MAX_WAIT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(MAX_WAIT - 1);

  logic [1:0]    state;
  logic [CW-1:0] wait_cnt;
  logic [2:0]    op_q;
  logic [1:0]    lo_q;

  logic        done_q, adel_q, ades_q, err_q, m_req_q, m_we_q;
  logic [31:0] rdata_q, m_addr_q, m_wdata_q;
  logic [3:0]  m_byteen_q;

  logic        is_load;
  logic        misaligned;
  logic [3:0]  be_next;
  logic [31:0] wd_next;
  logic [15:0] half_sel;
  logic [7:0]  byte_sel;
  logic [31:0] load_ext;

  // Decode the incoming instruction: direction, alignment, lanes and store data.
  always_comb begin
    is_load    = (bus.mem_op <= OP_LBU);
    misaligned = 1'b0;
    be_next    = 4'b0000;
    wd_next    = bus.wdata;
    case (bus.mem_op)
      OP_LW, OP_SW:         misaligned = (bus.addr[1:0] != 2'b00);
      OP_LH, OP_LHU, OP_SH: misaligned = bus.addr[0];
      default:              misaligned = 1'b0;
    endcase
    case (bus.mem_op)
      OP_SW: begin
        be_next = 4'b1111;
        wd_next = bus.wdata;
      end
      OP_SH: begin
        be_next = bus.addr[1] ? 4'b1100 : 4'b0011;
        wd_next = {2{bus.wdata[15:0]}};
      end
      OP_SB: begin
        be_next = 4'b0001 << bus.addr[1:0];
        wd_next = {4{bus.wdata[7:0]}};
      end
      default: begin
        be_next = 4'b0000;
        wd_next = bus.wdata;
      end
    endcase
  end

  // Pick the addressed lane of the returned word and extend it for the latched op.
  always_comb begin
    half_sel = lo_q[1] ? bus.m_rdata[31:16] : bus.m_rdata[15:0];
    byte_sel = bus.m_rdata[{lo_q, 3'b000} +: 8];
    case (op_q)
      OP_LH:   load_ext = {{16{half_sel[15]}}, half_sel};
      OP_LHU:  load_ext = {16'h0000, half_sel};
      OP_LB:   load_ext = {{24{byte_sel[7]}}, byte_sel};
      OP_LBU:  load_ext = {24'h000000, byte_sel};
      default: load_ext = bus.m_rdata;
    endcase
  end

  // Access sequencer: IDLE issues or faults, REQ waits for ack/timeout, DONE retires.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= S_IDLE;
      wait_cnt   <= '0;
      op_q       <= 3'b000;
      lo_q       <= 2'b00;
      done_q     <= 1'b0;
      adel_q     <= 1'b0;
      ades_q     <= 1'b0;
      err_q      <= 1'b0;
      rdata_q    <= 32'h0;
      m_req_q    <= 1'b0;
      m_addr_q   <= 32'h0;
      m_we_q     <= 1'b0;
      m_byteen_q <= 4'b0000;
      m_wdata_q  <= 32'h0;
    end else begin
      case (state)
        S_IDLE: begin
          if (bus.req_valid) begin
            if (misaligned) begin
              adel_q <= is_load;
              ades_q <= !is_load;
              done_q <= 1'b1;
              state  <= S_DONE;
            end else begin
              op_q       <= bus.mem_op;
              lo_q       <= bus.addr[1:0];
              m_addr_q   <= {bus.addr[31:2], 2'b00};
              m_we_q     <= !is_load;
              m_byteen_q <= be_next;
              m_wdata_q  <= wd_next;
              m_req_q    <= 1'b1;
              wait_cnt   <= '0;
              state      <= S_REQ;
            end
          end
        end
        S_REQ: begin
          if (bus.m_ack) begin
            // An ack always wins, even in the cycle the timeout would fire.
            m_req_q <= 1'b0;
            if (!m_we_q) rdata_q <= load_ext;
            done_q  <= 1'b1;
            state   <= S_DONE;
          end else if (wait_cnt == CNT_LAST) begin
            m_req_q <= 1'b0;
            err_q   <= 1'b1;
            done_q  <= 1'b1;
            state   <= S_DONE;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
        end
        S_DONE: begin
          // req_valid still shows the retiring instruction here; ignore it.
          done_q <= 1'b0;
          adel_q <= 1'b0;
          ades_q <= 1'b0;
          err_q  <= 1'b0;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Stall while an instruction is being accepted or is on the bus; released in DONE.
  assign bus.busy     = ((state == S_IDLE) && bus.req_valid) || (state == S_REQ);
  assign bus.done     = done_q;
  assign bus.rdata    = rdata_q;
  assign bus.adel     = adel_q;
  assign bus.ades     = ades_q;
  assign bus.err      = err_q;
  assign bus.m_req    = m_req_q;
  assign bus.m_addr   = m_addr_q;
  assign bus.m_we     = m_we_q;
  assign bus.m_byteen = m_byteen_q;
  assign bus.m_wdata  = m_wdata_q;
  assign state_dbg    = state;

endmodule

// File: tb/tb_m_mem_access.sv
// Bench for m_mem_access: directed scenarios plus randomized accesses against
// a behavioural model of lane formatting, extension, alignment and timeout.
`timescale 1ns/1ps
module tb_m_mem_access;
  localparam int MAX_WAIT = 4;
  localparam int NEVER    = -1;

  logic        clk = 1'b0;
  logic        reset;
  logic [1:0]  state_dbg;
  int          checks = 0;
  int          errors = 0;
  logic [31:0] last_rdata;
  logic [31:0] exp_q[$];

  m_mem_if bus();

  m_mem_access #(.MAX_WAIT(MAX_WAIT)) dut (
    .clk       (clk),
    .reset     (reset),
    .bus       (bus),
    .state_dbg (state_dbg)
  );

  // Clock.
  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  function automatic bit model_is_load(input logic [2:0] op);
    return op <= 3'd4;
  endfunction

  function automatic bit model_misaligned(input logic [2:0] op, input logic [31:0] a);
    if (op == 3'd0 || op == 3'd5) return (a % 4) != 0;
    if (op == 3'd1 || op == 3'd2 || op == 3'd6) return (a % 2) != 0;
    return 1'b0;
  endfunction

  function automatic logic [3:0] model_byteen(input logic [2:0] op, input logic [31:0] a);
    int lane;
    lane = a % 4;
    case (op)
      3'd5: return 4'hF;
      3'd6: return (lane >= 2) ? 4'hC : 4'h3;
      3'd7: return 4'(1 << lane);
      default: return 4'h0;
    endcase
  endfunction

  function automatic logic [31:0] model_wdata(input logic [2:0] op, input logic [31:0] w);
    logic [31:0] h, b;
    h = w % 65536;
    b = w % 256;
    if (op == 3'd6) return h * 65536 + h;
    if (op == 3'd7) return b * 32'h01010101;
    return w;
  endfunction

  function automatic logic [31:0] model_load(input logic [2:0] op, input logic [31:0] a,
                                             input logic [31:0] w);
    logic [31:0] h, b;
    int lane;
    lane = a % 4;
    h = (lane >= 2) ? (w / 65536) : (w % 65536);
    b = (w >> (8 * lane)) % 256;
    case (op)
      3'd1: return (h >= 32768) ? (h + 32'hFFFF0000) : h;
      3'd2: return h;
      3'd3: return (b >= 128) ? (b + 32'hFFFFFF00) : b;
      3'd4: return b;
      default: return w;
    endcase
  endfunction

  // ---------------- driver / checker ----------------
  // Issues one instruction starting at the next negedge and follows it to done.
  // ack_at is the 0-based REQ cycle in which m_ack is given (NEVER = no ack).
  // req_valid is left high through the DONE cycle, as a stalled pipeline would.
  task automatic run_access(input logic [2:0] op, input logic [31:0] a, input logic [31:0] wd,
                            input int ack_at, input logic [31:0] rw, input string name);
    bit          mis, ld, acked;
    int          exp_reqs, exp_cyc, cyc, nreq;
    bit          got;
    logic [31:0] exp_r;
    mis = model_misaligned(op, a);
    ld  = model_is_load(op);
    acked = !mis && ack_at >= 0 && ack_at < MAX_WAIT;
    if (mis) begin
      exp_reqs = 0;
      exp_cyc  = 2;
    end else if (acked) begin
      exp_reqs = ack_at + 1;
      exp_cyc  = 3 + ack_at;
    end else begin
      exp_reqs = MAX_WAIT;
      exp_cyc  = 2 + MAX_WAIT;
    end
    if (acked && ld) last_rdata = model_load(op, a, rw);
    exp_q.push_back(last_rdata);

    @(negedge clk);
    bus.req_valid = 1'b1;
    bus.mem_op    = op;
    bus.addr      = a;
    bus.wdata     = wd;
    bus.m_ack     = 1'b0;
    bus.m_rdata   = $urandom;
    #1;
    checks++;
    if (bus.busy !== 1'b1) begin
      errors++;
      $display("FAIL %s busy_accept got %b want 1", name, bus.busy);
    end

    cyc = 1; nreq = 0; got = 0;
    while (!got && cyc < 40) begin
      @(negedge clk);
      cyc++;
      bus.m_ack   = 1'b0;
      bus.m_rdata = $urandom;
      if (bus.m_req === 1'b1) begin
        checks++;
        if (bus.m_addr !== {a[31:2], 2'b00} || bus.m_we !== !ld ||
            bus.m_byteen !== model_byteen(op, a) || bus.busy !== 1'b1 ||
            (!ld && bus.m_wdata !== model_wdata(op, wd))) begin
          errors++;
          $display("FAIL %s bus_fields got addr=%h we=%b be=%b wd=%h busy=%b want addr=%h we=%b be=%b wd=%h busy=1",
                   name, bus.m_addr, bus.m_we, bus.m_byteen, bus.m_wdata, bus.busy,
                   {a[31:2], 2'b00}, !ld, model_byteen(op, a), model_wdata(op, wd));
        end
        if (nreq == ack_at) begin
          bus.m_ack   = 1'b1;
          bus.m_rdata = rw;
        end
        nreq++;
      end
      if (bus.done === 1'b1) got = 1;
    end

    if (!got) begin
      errors++;
      $display("FAIL %s done_timeout got no done want done by cycle %0d", name, exp_cyc);
    end else begin
      exp_r = exp_q.pop_front();
      checks++;
      if (cyc != exp_cyc || nreq != exp_reqs) begin
        errors++;
        $display("FAIL %s latency got cycle=%0d reqs=%0d want cycle=%0d reqs=%0d",
                 name, cyc, nreq, exp_cyc, exp_reqs);
      end
      checks++;
      if (bus.adel !== (mis && ld) || bus.ades !== (mis && !ld) ||
          bus.err !== (!mis && !acked) || bus.busy !== 1'b0) begin
        errors++;
        $display("FAIL %s flags got adel=%b ades=%b err=%b busy=%b want adel=%b ades=%b err=%b busy=0",
                 name, bus.adel, bus.ades, bus.err, bus.busy, mis && ld, mis && !ld, !mis && !acked);
      end
      checks++;
      if (bus.rdata !== exp_r) begin
        errors++;
        $display("FAIL %s rdata got %h want %h", name, bus.rdata, exp_r);
      end
    end
  endtask

  // One cycle with no instruction: nothing may be requested or retired.
  task automatic idle_check(input string name);
    @(negedge clk);
    bus.req_valid = 1'b0;
    bus.m_ack     = 1'b0;
    #1;
    checks++;
    if (bus.m_req !== 1'b0 || bus.done !== 1'b0 || bus.busy !== 1'b0) begin
      errors++;
      $display("FAIL %s idle got m_req=%b done=%b busy=%b want 0 0 0",
               name, bus.m_req, bus.done, bus.busy);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b1;
    bus.req_valid = 1'b0; bus.mem_op = 3'd0; bus.addr = 32'h0; bus.wdata = 32'h0;
    bus.m_ack = 1'b0; bus.m_rdata = 32'h0;
    last_rdata = 32'h0;
    repeat (3) @(negedge clk);
    checks++;
    if ({bus.busy, bus.done, bus.adel, bus.ades, bus.err, bus.m_req, bus.m_we, bus.m_byteen} !== 11'h0 ||
        bus.rdata !== 32'h0 || bus.m_addr !== 32'h0 || bus.m_wdata !== 32'h0 || state_dbg !== 2'd0) begin
      errors++;
      $display("FAIL reset outputs got done=%b m_req=%b be=%b rdata=%h m_addr=%h st=%0d want all 0",
               bus.done, bus.m_req, bus.m_byteen, bus.rdata, bus.m_addr, state_dbg);
    end
    reset = 1'b0;
    idle_check("reset_release");
  endtask

  task automatic test_load_byte();
    run_access(3'd3, 32'h103, 32'h0, 0, 32'h80FF1234, "lb_0x103");
    idle_check("lb_after");
  endtask

  task automatic test_store_half();
    run_access(3'd6, 32'h202, 32'hDEADBEEF, 0, 32'h0, "sh_0x202");
    idle_check("sh_after");
  endtask

  task automatic test_misaligned();
    run_access(3'd0, 32'h001, 32'h0, 0, 32'h0, "lw_misaligned");
    idle_check("lw_mis_after");
    run_access(3'd6, 32'h003, 32'h1234, 0, 32'h0, "sh_misaligned");
    idle_check("sh_mis_after");
  endtask

  task automatic test_timeout();
    run_access(3'd0, 32'h010, 32'h0, NEVER, 32'h0, "lw_timeout");
    idle_check("timeout_after");
    run_access(3'd0, 32'h014, 32'h0, MAX_WAIT - 1, 32'hCAFEF00D, "lw_ack_last");
    idle_check("ack_last_after");
  endtask

  task automatic test_mid_reset();
    @(negedge clk);
    bus.req_valid = 1'b1; bus.mem_op = 3'd0; bus.addr = 32'h40; bus.m_ack = 1'b0;
    @(negedge clk);
    checks++;
    if (bus.m_req !== 1'b1) begin
      errors++;
      $display("FAIL midreset_req got m_req=%b want 1", bus.m_req);
    end
    reset = 1'b1;
    bus.req_valid = 1'b0;
    last_rdata = 32'h0;
    @(negedge clk);
    checks++;
    if (bus.m_req !== 1'b0 || bus.busy !== 1'b0 || bus.done !== 1'b0) begin
      errors++;
      $display("FAIL midreset_drop got m_req=%b busy=%b done=%b want 0 0 0",
               bus.m_req, bus.busy, bus.done);
    end
    reset = 1'b0;
    repeat (3) idle_check("midreset_quiet");
    run_access(3'd2, 32'h002, 32'h0, 0, 32'h8001FFFF, "lhu_after_reset");
    idle_check("lhu_after");
  endtask

  task automatic test_back_to_back();
    run_access(3'd7, 32'h301, 32'h000000A5, 1, 32'h0, "b2b_sb");
    run_access(3'd4, 32'h302, 32'h0, 0, 32'h11C32233, "b2b_lbu");
    idle_check("b2b_after");
  endtask

  task automatic test_random();
    logic [2:0]  op;
    logic [31:0] a;
    int          ack;
    for (int i = 0; i < 60; i++) begin
      op  = 3'($urandom_range(0, 7));
      a   = $urandom;
      if ($urandom_range(0, 3) != 0) a[1:0] = 2'b00;
      ack = $urandom_range(0, MAX_WAIT + 1);
      if (ack > MAX_WAIT) ack = NEVER;
      run_access(op, a, $urandom, ack, $urandom, "random");
      if ($urandom_range(0, 1) == 1) idle_check("random_gap");
    end
    idle_check("random_end");
  endtask

  initial begin
    test_reset();
    test_load_byte();
    test_store_half();
    test_misaligned();
    test_timeout();
    test_mid_reset();
    test_back_to_back();
    test_random();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
